// File: rtl/obi_sram_pkg.sv
// Shared definitions for the pipelined OBI SRAM subordinate: response payload,
// word geometry for the default 32-bit configuration, and the address range check.
package obi_sram_pkg;

    localparam int unsigned OBI_DATA_WIDTH   = 32;
    localparam int unsigned BYTES_PER_WORD   = OBI_DATA_WIDTH / 8;
    localparam int unsigned WORD_OFFSET_BITS = $clog2(BYTES_PER_WORD);

    typedef struct packed {
        logic [OBI_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } obi_rsp_t;

    // Subtract-then-compare so base + span never has to be representable.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-order response queue with synchronous reset; payload type supplied by the user.
module obi_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push,
    input  logic                         pop,
    input  T                             wdata,
    output T                             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

    T                     store [DEPTH];
    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;

    function automatic logic [PTR_WIDTH-1:0] bump(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push) begin
            store[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= bump(wptr);
            end
            if (pop) begin
                rptr <= bump(rptr);
            end
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    assign rdata = store[rptr];
    assign full  = (count == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/obi_sram_slave_pl.sv
// Pipelined OBI subordinate over a byte-masked word SRAM with range errors and
// up to RSP_DEPTH outstanding responses (S1 stage plus in-order response FIFO).
module obi_sram_slave_pl
    import obi_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 64,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o
);

    localparam int unsigned BYTES       = DATA_WIDTH / 8;
    localparam int unsigned OFFSET_BITS = $clog2(BYTES);
    localparam int unsigned INDEX_WIDTH = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_WIDTH   = $clog2(RSP_DEPTH + 1);
    localparam logic [63:0] SPAN        = 64'(MEM_DEPTH) * 64'(BYTES);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic [ADDR_WIDTH-1:0]  offset;
    logic [INDEX_WIDTH-1:0] index;
    logic                   hit;
    logic                   accept;
    logic                   retire;
    logic                   gnt;
    logic                   s1_valid;
    logic                   s1_err;
    logic                   s1_rd;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_WIDTH-1:0]   fifo_count;
    logic [CNT_WIDTH-1:0]   outstanding;
    logic [CNT_WIDTH-1:0]   outstanding_next;
    rsp_t                   s1_rsp;
    rsp_t                   head;
    rsp_t                   rsp;

    assign hit    = in_range(64'(obi_addr_i), BASE_ADDR, SPAN);
    assign offset = obi_addr_i - ADDR_WIDTH'(BASE_ADDR);
    assign index  = INDEX_WIDTH'(offset >> OFFSET_BITS);
    assign accept = obi_req_i && gnt;
    assign retire = obi_rvalid_o && obi_rready_i;

    // Writes commit at the accept edge, so a read accepted next sees the new word.
    always_ff @(posedge clk_i) begin
        if (accept && hit) begin
            if (obi_we_i) begin
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (obi_be_i[b]) begin
                        mem[index][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                    end
                end
            end else begin
                mem_rdata <= mem[index];
            end
        end
    end

    assign outstanding      = CNT_WIDTH'(s1_valid) + fifo_count;
    assign outstanding_next = outstanding + CNT_WIDTH'(accept) - CNT_WIDTH'(retire);

    // S1 lives exactly one cycle: it either retires directly or moves into the FIFO.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_rd    <= 1'b0;
            gnt      <= 1'b1;
        end else begin
            s1_valid <= accept;
            s1_err   <= accept && !hit;
            s1_rd    <= accept && hit && !obi_we_i;
            gnt      <= (outstanding_next < CNT_WIDTH'(RSP_DEPTH));
        end
    end

    assign s1_rsp.rdata = s1_rd ? mem_rdata : '0;
    assign s1_rsp.err   = s1_err;
    assign push         = s1_valid && !(fifo_empty && obi_rready_i);
    assign pop          = retire && !fifo_empty;
    assign rsp          = fifo_empty ? s1_rsp : head;

    obi_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .pop     (pop),
        .wdata   (s1_rsp),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign obi_gnt_o    = gnt;
    assign obi_rvalid_o = s1_valid || !fifo_empty;
    assign obi_rdata_o  = rsp.rdata;
    assign obi_err_o    = rsp.err;

    a_no_accept_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(accept && (outstanding == CNT_WIDTH'(RSP_DEPTH))));

    a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && fifo_full && !pop));

    a_stable_when_stalled: assert property (@(posedge clk_i) disable iff (reset_i)
        (obi_rvalid_o && !obi_rready_i) |=>
            (obi_rvalid_o && $stable(obi_rdata_o) && $stable(obi_err_o)));

    a_no_x_handshake: assert property (@(posedge clk_i)
        !reset_i |-> !$isunknown({obi_rvalid_o, obi_gnt_o}));

endmodule

// File: tb/tb_obi_sram_slave_pl.sv
// Scoreboard bench for obi_sram_slave_pl: a 32-bit default instance and a 64-bit
// relocated instance, with a byte-level reference memory producing expected responses.
module tb_obi_sram_slave_pl;

    localparam int unsigned N_DEPTH = 64;
    localparam int unsigned W_DEPTH = 32;
    localparam logic [31:0] W_BASE  = 32'h8000;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_n = 0, gnt_n, we_n = 0, rvalid_n, rready_n = 1, err_n;
    logic [31:0] addr_n = 0, wdata_n = 0, rdata_n;
    logic [3:0]  be_n = 0;

    logic        req_w = 0, gnt_w, we_w = 0, rvalid_w, rready_w = 1, err_w;
    logic [31:0] addr_w = 0;
    logic [63:0] wdata_w = 0, rdata_w;
    logic [7:0]  be_w = 0;

    exp_t        exp_n[$];
    exp_t        exp_w[$];
    logic [63:0] m_n [N_DEPTH];
    logic [63:0] m_w [W_DEPTH];
    logic        stalled [2];
    logic [63:0] held_d [2];
    logic        held_e [2];

    int vectors = 0;
    int miscompares = 0;

    obi_sram_slave_pl u_dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .obi_req_i    (req_n),
        .obi_gnt_o    (gnt_n),
        .obi_addr_i   (addr_n),
        .obi_we_i     (we_n),
        .obi_be_i     (be_n),
        .obi_wdata_i  (wdata_n),
        .obi_rvalid_o (rvalid_n),
        .obi_rready_i (rready_n),
        .obi_rdata_o  (rdata_n),
        .obi_err_o    (err_n)
    );

    obi_sram_slave_pl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .MEM_DEPTH  (W_DEPTH),
        .BASE_ADDR  (64'h8000),
        .RSP_DEPTH  (2)
    ) u_dut_w (
        .clk_i        (clk),
        .reset_i      (reset),
        .obi_req_i    (req_w),
        .obi_gnt_o    (gnt_w),
        .obi_addr_i   (addr_w),
        .obi_we_i     (we_w),
        .obi_be_i     (be_w),
        .obi_wdata_i  (wdata_w),
        .obi_rvalid_o (rvalid_w),
        .obi_rready_i (rready_w),
        .obi_rdata_o  (rdata_w),
        .obi_err_o    (err_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one request, wait (bounded) for the accept edge, then push its expected response.
    task automatic issue(input bit wide, input logic [31:0] addr, input logic we,
                         input logic [7:0] be, input logic [63:0] wdata, output int stalls);
        exp_t e;
        logic ok;
        int   idx;
        stalls = 0;
        if (wide) begin
            req_w = 1; addr_w = addr; we_w = we; be_w = be; wdata_w = wdata;
        end else begin
            req_n = 1; addr_n = addr; we_n = we; be_n = be[3:0]; wdata_n = wdata[31:0];
        end
        while ((wide ? gnt_w : gnt_n) !== 1'b1 && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (stalls >= 50) begin
            check(wide ? "w_gnt_timeout" : "n_gnt_timeout", 64'(stalls), 0);
            req_w = 0; req_n = 0;
            return;
        end
        @(posedge clk); #1;
        if (wide) begin
            ok  = (addr >= W_BASE) && (addr < W_BASE + W_DEPTH * 8);
            idx = int'((addr - W_BASE) >> 3);
        end else begin
            ok  = (addr < N_DEPTH * 4);
            idx = int'(addr >> 2);
        end
        e.err   = !ok;
        e.rdata = 64'h0;
        if (ok && we) begin
            for (int b = 0; b < (wide ? 8 : 4); b++) begin
                if (be[b]) begin
                    if (wide) m_w[idx][8*b +: 8] = wdata[8*b +: 8];
                    else      m_n[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else if (ok) begin
            e.rdata = wide ? m_w[idx] : m_n[idx];
        end
        if (wide) exp_w.push_back(e);
        else      exp_n.push_back(e);
        if (wide) req_w = 0;
        else      req_n = 0;
    endtask

    task automatic observe(input int d, input logic v, input logic r,
                           input logic [63:0] data, input logic e);
        exp_t x;
        if (stalled[d]) begin
            check(d != 0 ? "w_stall_valid" : "n_stall_valid", 64'(v), 1);
            check(d != 0 ? "w_stall_rdata" : "n_stall_rdata", data, held_d[d]);
            check(d != 0 ? "w_stall_err" : "n_stall_err", 64'(e), 64'(held_e[d]));
        end
        if (v && r) begin
            if ((d != 0 ? exp_w.size() : exp_n.size()) == 0) begin
                check(d != 0 ? "w_unexpected_rsp" : "n_unexpected_rsp", 1, 0);
            end else begin
                if (d != 0) x = exp_w.pop_front();
                else        x = exp_n.pop_front();
                check(d != 0 ? "w_rdata" : "n_rdata", data, x.rdata);
                check(d != 0 ? "w_err" : "n_err", 64'(e), 64'(x.err));
            end
        end
        stalled[d] = v && !r;
        held_d[d]  = data;
        held_e[d]  = e;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stalled[0] = 1'b0;
            stalled[1] = 1'b0;
        end else begin
            observe(0, rvalid_n, rready_n, {32'h0, rdata_n}, err_n);
            observe(1, rvalid_w, rready_w, rdata_w, err_w);
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_n.size() != 0 || exp_w.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(exp_n.size() + exp_w.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        int st, st3, total;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("rst_gnt", 64'(gnt_n), 1);
        check("rst_rvalid", 64'(rvalid_n), 0);
        check("rst_rdata", 64'(rdata_n), 0);
        check("rst_err", 64'(err_n), 0);
        check("rst_w_gnt", 64'(gnt_w), 1);

        // Byte-masked write then read, minimum read latency
        issue(0, 32'h10, 1, 8'hF, 64'hAABBCCDD, st);
        issue(0, 32'h10, 1, 8'h5, 64'h11223344, st);
        issue(0, 32'h10, 0, 8'h0, 64'h0, st);
        check("rd_latency_valid", 64'(rvalid_n), 1);
        check("bytemask_rdata", 64'(rdata_n), 64'hAA22CC44);

        issue(0, 32'h0,  1, 8'hF, 64'h0BAD0000, st);
        issue(0, 32'h4,  1, 8'hF, 64'h0BAD0004, st);
        issue(0, 32'h8,  1, 8'hF, 64'h0BAD0008, st);
        issue(0, 32'hFC, 1, 8'hF, 64'h5A5A00FC, st);
        issue(0, 32'h8,  1, 8'h0, 64'hFFFFFFFF, st);
        drain();

        // Back-pressure: credit exhaustion and in-order release
        rready_n = 0;
        issue(0, 32'h0, 0, 8'h0, 64'h0, st);
        check("bp_first_stalls", 64'(st), 0);
        issue(0, 32'h4, 0, 8'h0, 64'h0, st);
        check("bp_second_stalls", 64'(st), 0);
        check("bp_gnt_low", 64'(gnt_n), 0);
        fork
            issue(0, 32'h8, 0, 8'h0, 64'h0, st3);
            begin
                repeat (3) @(posedge clk);
                #1 rready_n = 1;
            end
        join
        check("bp_third_stalls", 64'(st3), 4);
        drain();

        // Out-of-range accesses and the last valid word
        issue(0, 32'h100, 0, 8'h0, 64'h0, st);
        check("oor_rd_err", 64'(err_n), 1);
        check("oor_rd_rdata", 64'(rdata_n), 0);
        issue(0, 32'h100, 1, 8'hF, 64'hDEADBEEF, st);
        issue(0, 32'hFC, 0, 8'h0, 64'h0, st);
        check("last_word_err", 64'(err_n), 0);
        issue(0, 32'h0, 0, 8'h0, 64'h0, st);
        drain();

        // Reset with responses stalled in flight; memory retains contents
        rready_n = 0;
        issue(0, 32'h0, 0, 8'h0, 64'h0, st);
        issue(0, 32'h4, 0, 8'h0, 64'h0, st);
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        exp_n.delete();
        check("rst2_gnt", 64'(gnt_n), 1);
        check("rst2_rvalid", 64'(rvalid_n), 0);
        check("rst2_rdata", 64'(rdata_n), 0);
        check("rst2_err", 64'(err_n), 0);
        rready_n = 1;
        issue(0, 32'h10, 0, 8'h0, 64'h0, st);
        check("rst2_retained", 64'(rdata_n), 64'hAA22CC44);
        drain();

        // Full-rate alternating write/read to one word
        total = 0;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            issue(0, 32'h20, 1, 8'hF, {32'h0, d}, st);
            total += st;
            issue(0, 32'h20, 0, 8'h0, 64'h0, st);
            total += st;
        end
        check("throughput_stalls", 64'(total), 0);
        drain();

        // 64-bit relocated instance
        issue(1, 32'h8008, 1, 8'hFF, 64'hFFEEDDCCBBAA9988, st);
        issue(1, 32'h8008, 1, 8'hF0, 64'h0123456789ABCDEF, st);
        issue(1, 32'h8008, 0, 8'h00, 64'h0, st);
        check("w_mask_rdata", rdata_w, 64'h01234567BBAA9988);
        issue(1, 32'h7FF8, 0, 8'h00, 64'h0, st);
        check("w_below_base_err", 64'(err_w), 1);
        issue(1, 32'h80F8, 1, 8'hFF, 64'hCAFEF00D12345678, st);
        issue(1, 32'h80F8, 0, 8'h00, 64'h0, st);
        check("w_last_word_err", 64'(err_w), 0);
        issue(1, 32'h8100, 0, 8'h00, 64'h0, st);
        check("w_past_end_err", 64'(err_w), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
